// File: rtl/hsi_mse_argmin.sv
// Argmin tracker for one pixel's library search: keeps the smallest MSE and its library
// reference, then offers the winner to the classifier over a valid/ready handshake.
module hsi_mse_argmin #(
    parameter int WORD_WIDTH       = 32,
    parameter int HSI_LIBRARY_SIZE = 16,
    parameter int REF_W            = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  search_start,
    input  logic [WORD_WIDTH-1:0] mse_value,
    input  logic [REF_W-1:0]      mse_ref,
    input  logic                  mse_valid,
    input  logic                  result_ready,
    output logic                  result_valid,
    output logic [WORD_WIDTH-1:0] min_mse_value,
    output logic [REF_W-1:0]      min_mse_ref,
    output logic [REF_W:0]        sample_count,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [REF_W:0] LIB_SIZE = (REF_W+1)'(HSI_LIBRARY_SIZE);
    localparam logic [REF_W:0] ONE      = {{REF_W{1'b0}}, 1'b1};
    localparam logic [REF_W:0] ZERO_CNT = {(REF_W+1){1'b0}};

    logic [1:0]            state_r, state_s;
    logic [WORD_WIDTH-1:0] min_value_r, min_value_s;
    logic [REF_W-1:0]      min_ref_r, min_ref_s;
    logic [REF_W:0]        count_r, count_s;
    logic [REF_W:0]        count_inc_s;
    logic                  overrun_r, overrun_s;
    logic                  result_valid_r, busy_r;
    logic                  take_s;

    // Next-state and tracker update; a start in any state clears the tracker.
    always_comb begin
        state_s     = state_r;
        min_value_s = min_value_r;
        min_ref_s   = min_ref_r;
        count_s     = count_r;
        overrun_s   = overrun_r;
        count_inc_s = count_r + ONE;
        // First sample of a search loads unconditionally; later ones only on a strict improvement.
        take_s      = (count_r == ZERO_CNT) || (mse_value < min_value_r);

        if (search_start) begin
            state_s     = ST_COLLECT;
            min_value_s = {WORD_WIDTH{1'b0}};
            min_ref_s   = {REF_W{1'b0}};
            count_s     = ZERO_CNT;
            overrun_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mse_valid) begin
                        overrun_s = 1'b1;
                    end else begin
                        overrun_s = overrun_r;
                    end
                end
                ST_COLLECT: begin
                    if (mse_valid) begin
                        count_s = count_inc_s;
                        if (take_s) begin
                            min_value_s = mse_value;
                            min_ref_s   = mse_ref;
                        end else begin
                            min_value_s = min_value_r;
                        end
                        if (count_inc_s == LIB_SIZE) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_COLLECT;
                        end
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    if (mse_valid) begin
                        overrun_s = 1'b1;
                    end else begin
                        overrun_s = overrun_r;
                    end
                    if (result_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            min_value_r    <= {WORD_WIDTH{1'b0}};
            min_ref_r      <= {REF_W{1'b0}};
            count_r        <= ZERO_CNT;
            overrun_r      <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            min_value_r    <= min_value_s;
            min_ref_r      <= min_ref_s;
            count_r        <= count_s;
            overrun_r      <= overrun_s;
            result_valid_r <= (state_s == ST_DONE);
            busy_r         <= (state_s == ST_COLLECT);
        end
    end

    assign result_valid  = result_valid_r;
    assign min_mse_value = min_value_r;
    assign min_mse_ref   = min_ref_r;
    assign sample_count  = count_r;
    assign busy          = busy_r;
    assign overrun       = overrun_r;

endmodule
